// File: rtl/issue_bypass_xbar_pkg.sv
// rtl/issue_bypass_xbar_pkg.sv - shared parameters and helpers for the issue bypass crossbar
package issue_bypass_xbar_pkg;

  localparam int unsigned DEF_LANES     = 3;
  localparam int unsigned DEF_UNITS     = 4;
  localparam int unsigned DEF_WB_PORTS  = 4;
  localparam int unsigned DEF_XLEN      = 32;
  localparam int unsigned DEF_WIDTH_REG = 7;
  localparam int unsigned DEF_WIDTH_PL  = 48;

  // Upper bound on snooped writeback buses; hit vectors are padded to this width.
  localparam int unsigned MAX_WB_PORTS  = 32;

  // Physical register 0 is hard-wired and must never pick up a bypass.
  localparam int unsigned TAG_ZERO      = 0;

  function automatic int unsigned sel_width(input int unsigned units);
    return (units > 1) ? $clog2(units) : 1;
  endfunction

  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  // Lowest-numbered writeback port wins when several carry the same tag.
  function automatic int first_hit(input logic [MAX_WB_PORTS-1:0] hit);
    first_hit = -1;
    for (int p = MAX_WB_PORTS - 1; p >= 0; p--) begin
      if (hit[p]) begin
        first_hit = p;
      end
    end
  endfunction

endpackage

// File: rtl/issue_bypass_xbar_if.sv
// rtl/issue_bypass_xbar_if.sv - issue-lane, writeback and functional-unit signal bundle
interface issue_bypass_xbar_if
  import issue_bypass_xbar_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned UNITS     = DEF_UNITS,
  parameter int unsigned WB_PORTS  = DEF_WB_PORTS,
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned WIDTH_REG = DEF_WIDTH_REG,
  parameter int unsigned WIDTH_PL  = DEF_WIDTH_PL,
  parameter int unsigned WIDTH_SEL = sel_width(UNITS)
);

  logic [LANES-1:0]              i_valid;
  logic [LANES*WIDTH_SEL-1:0]    i_unit;
  logic [LANES*WIDTH_REG-1:0]    i_rs1_tag;
  logic [LANES*WIDTH_REG-1:0]    i_rs2_tag;
  logic [LANES*XLEN-1:0]         i_rs1_data;
  logic [LANES*XLEN-1:0]         i_rs2_data;
  logic [LANES*WIDTH_PL-1:0]     i_payload;
  logic [LANES-1:0]              o_ready;

  logic [WB_PORTS-1:0]           i_wb_valid;
  logic [WB_PORTS*WIDTH_REG-1:0] i_wb_tag;
  logic [WB_PORTS*XLEN-1:0]      i_wb_data;

  logic [UNITS-1:0]              o_fu_valid;
  logic [UNITS*XLEN-1:0]         o_fu_rs1;
  logic [UNITS*XLEN-1:0]         o_fu_rs2;
  logic [UNITS*WIDTH_PL-1:0]     o_fu_payload;
  logic [UNITS-1:0]              i_fu_ready;

  logic [15:0]                   o_conflict_cnt;
  logic                          o_err;

  modport master (
    output i_valid, i_unit, i_rs1_tag, i_rs2_tag, i_rs1_data, i_rs2_data, i_payload,
    output i_wb_valid, i_wb_tag, i_wb_data, i_fu_ready,
    input  o_ready, o_fu_valid, o_fu_rs1, o_fu_rs2, o_fu_payload, o_conflict_cnt, o_err
  );

  modport slave (
    input  i_valid, i_unit, i_rs1_tag, i_rs2_tag, i_rs1_data, i_rs2_data, i_payload,
    input  i_wb_valid, i_wb_tag, i_wb_data, i_fu_ready,
    output o_ready, o_fu_valid, o_fu_rs1, o_fu_rs2, o_fu_payload, o_conflict_cnt, o_err
  );

endinterface

// File: rtl/issue_bypass_xbar_bypass_resolve.sv
// rtl/issue_bypass_xbar_bypass_resolve.sv - picks writeback data over register-file data on tag match
module issue_bypass_xbar_bypass_resolve
  import issue_bypass_xbar_pkg::*;
#(
  parameter int unsigned WB_PORTS  = DEF_WB_PORTS,
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned WIDTH_REG = DEF_WIDTH_REG
) (
  input  logic [WIDTH_REG-1:0]          tag_i,
  input  logic [XLEN-1:0]               rf_data_i,
  input  logic [WB_PORTS-1:0]           wb_valid_i,
  input  logic [WB_PORTS*WIDTH_REG-1:0] wb_tag_i,
  input  logic [WB_PORTS*XLEN-1:0]      wb_data_i,
  output logic [XLEN-1:0]               data_o
);

  logic [MAX_WB_PORTS-1:0] hit;
  int                      sel;

  always_comb begin
    hit = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      hit[p] = wb_valid_i[p] && (wb_tag_i[p*WIDTH_REG +: WIDTH_REG] == tag_i);
    end
    sel    = first_hit(hit);
    data_o = rf_data_i;
    if (tag_i != WIDTH_REG'(TAG_ZERO)) begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (p == sel) begin
          data_o = wb_data_i[p*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/issue_bypass_xbar.sv
// rtl/issue_bypass_xbar.sv - routes issued uops to per-unit registered slots with operand bypass
module issue_bypass_xbar
  import issue_bypass_xbar_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned UNITS     = DEF_UNITS,
  parameter int unsigned WB_PORTS  = DEF_WB_PORTS,
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned WIDTH_REG = DEF_WIDTH_REG,
  parameter int unsigned WIDTH_PL  = DEF_WIDTH_PL,
  parameter int unsigned WIDTH_SEL = sel_width(UNITS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  issue_bypass_xbar_if.slave xbar
);

  logic [XLEN-1:0]      rs1_res   [LANES];
  logic [XLEN-1:0]      rs2_res   [LANES];
  logic [WIDTH_SEL-1:0] lane_unit [LANES];
  logic [LANES-1:0]     in_range;
  logic [LANES-1:0]     won;
  logic [LANES-1:0]     ready;
  logic [LANES-1:0]     lost;
  logic [UNITS-1:0]     slot_free;

  logic [UNITS-1:0]     acc;
  logic [XLEN-1:0]      acc_rs1   [UNITS];
  logic [XLEN-1:0]      acc_rs2   [UNITS];
  logic [WIDTH_PL-1:0]  acc_pl    [UNITS];

  logic [UNITS-1:0]     valid_q,  valid_d;
  logic [XLEN-1:0]      rs1_q     [UNITS];
  logic [XLEN-1:0]      rs1_d     [UNITS];
  logic [XLEN-1:0]      rs2_q     [UNITS];
  logic [XLEN-1:0]      rs2_d     [UNITS];
  logic [WIDTH_PL-1:0]  pl_q      [UNITS];
  logic [WIDTH_PL-1:0]  pl_d      [UNITS];
  logic [15:0]          cnt_q,    cnt_d;
  logic                 err_q,    err_d;
  logic [16:0]          lost_cnt;
  logic [16:0]          cnt_sum;

  for (genvar l = 0; l < LANES; l++) begin : g_resolve
    issue_bypass_xbar_bypass_resolve #(
      .WB_PORTS (WB_PORTS),
      .XLEN     (XLEN),
      .WIDTH_REG(WIDTH_REG)
    ) u_rs1 (
      .tag_i     (xbar.i_rs1_tag[field_lsb(l, WIDTH_REG) +: WIDTH_REG]),
      .rf_data_i (xbar.i_rs1_data[field_lsb(l, XLEN) +: XLEN]),
      .wb_valid_i(xbar.i_wb_valid),
      .wb_tag_i  (xbar.i_wb_tag),
      .wb_data_i (xbar.i_wb_data),
      .data_o    (rs1_res[l])
    );
    issue_bypass_xbar_bypass_resolve #(
      .WB_PORTS (WB_PORTS),
      .XLEN     (XLEN),
      .WIDTH_REG(WIDTH_REG)
    ) u_rs2 (
      .tag_i     (xbar.i_rs2_tag[field_lsb(l, WIDTH_REG) +: WIDTH_REG]),
      .rf_data_i (xbar.i_rs2_data[field_lsb(l, XLEN) +: XLEN]),
      .wb_valid_i(xbar.i_wb_valid),
      .wb_tag_i  (xbar.i_wb_tag),
      .wb_data_i (xbar.i_wb_data),
      .data_o    (rs2_res[l])
    );
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_unit[l] = xbar.i_unit[l*WIDTH_SEL +: WIDTH_SEL];
      in_range[l]  = 32'(lane_unit[l]) < UNITS;
    end
  end

  assign slot_free = ~valid_q | xbar.i_fu_ready;

  // Out-of-range lanes never block anyone, so they always count as winners.
  always_comb begin
    won = '1;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < l; j++) begin
        if (xbar.i_valid[j] && in_range[j] && in_range[l] &&
            (lane_unit[j] == lane_unit[l])) begin
          won[l] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int l = 0; l < LANES; l++) begin
      if (xbar.i_valid[l]) begin
        if (!in_range[l]) begin
          ready[l] = 1'b1;
        end else begin
          for (int u = 0; u < UNITS; u++) begin
            if (lane_unit[l] == WIDTH_SEL'(u)) begin
              ready[l] = won[l] & slot_free[u];
            end
          end
        end
      end
    end
  end

  // At most one lane per unit can be ready, so the per-unit mux has no priority.
  always_comb begin
    acc = '0;
    for (int u = 0; u < UNITS; u++) begin
      acc_rs1[u] = '0;
      acc_rs2[u] = '0;
      acc_pl[u]  = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      for (int u = 0; u < UNITS; u++) begin
        if (ready[l] && in_range[l] && (lane_unit[l] == WIDTH_SEL'(u))) begin
          acc[u]     = 1'b1;
          acc_rs1[u] = rs1_res[l];
          acc_rs2[u] = rs2_res[l];
          acc_pl[u]  = xbar.i_payload[l*WIDTH_PL +: WIDTH_PL];
        end
      end
    end
  end

  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      valid_d[u] = valid_q[u] & ~xbar.i_fu_ready[u];
      rs1_d[u]   = rs1_q[u];
      rs2_d[u]   = rs2_q[u];
      pl_d[u]    = pl_q[u];
      if (acc[u]) begin
        valid_d[u] = 1'b1;
        rs1_d[u]   = acc_rs1[u];
        rs2_d[u]   = acc_rs2[u];
        pl_d[u]    = acc_pl[u];
      end
    end
  end

  assign lost = xbar.i_valid & ~won;

  always_comb begin
    lost_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      lost_cnt = lost_cnt + 17'(lost[l]);
    end
    cnt_sum = {1'b0, cnt_q} + lost_cnt;
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    err_d   = err_q | (|(xbar.i_valid & ~in_range));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int u = 0; u < UNITS; u++) begin
        rs1_q[u] <= '0;
        rs2_q[u] <= '0;
        pl_q[u]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      for (int u = 0; u < UNITS; u++) begin
        rs1_q[u] <= rs1_d[u];
        rs2_q[u] <= rs2_d[u];
        pl_q[u]  <= pl_d[u];
      end
    end
  end

  always_comb begin
    xbar.o_fu_rs1     = '0;
    xbar.o_fu_rs2     = '0;
    xbar.o_fu_payload = '0;
    for (int u = 0; u < UNITS; u++) begin
      xbar.o_fu_rs1[u*XLEN +: XLEN]             = rs1_q[u];
      xbar.o_fu_rs2[u*XLEN +: XLEN]             = rs2_q[u];
      xbar.o_fu_payload[u*WIDTH_PL +: WIDTH_PL] = pl_q[u];
    end
  end

  assign xbar.o_ready        = ready;
  assign xbar.o_fu_valid     = valid_q;
  assign xbar.o_conflict_cnt = cnt_q;
  assign xbar.o_err          = err_q;

endmodule

// File: tb/tb_issue_bypass_xbar.sv
// tb/tb_issue_bypass_xbar.sv - scoreboard bench for issue_bypass_xbar
module tb_issue_bypass_xbar;

  localparam int L  = 3;
  localparam int U  = 4;
  localparam int S  = 2;
  localparam int PL = 48;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [47:0] pl;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq [U][$];

  always #5 clk = ~clk;

  issue_bypass_xbar_if bus ();
  issue_bypass_xbar dut (.i_clk(clk), .i_rst_n(rst_n), .xbar(bus));

  issue_bypass_xbar_if #(.UNITS(3)) bus3 ();
  issue_bypass_xbar #(.UNITS(3)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .xbar(bus3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_lanes();
    bus.i_valid    = '0;
    bus.i_unit     = '0;
    bus.i_rs1_tag  = '0;
    bus.i_rs2_tag  = '0;
    bus.i_rs1_data = '0;
    bus.i_rs2_data = '0;
    bus.i_payload  = '0;
    bus.i_wb_valid = '0;
    bus.i_wb_tag   = '0;
    bus.i_wb_data  = '0;
  endtask

  task automatic set_lane(input int l, input int unit, input logic [6:0] t1, input logic [31:0] d1,
                          input logic [6:0] t2, input logic [31:0] d2, input logic [47:0] pl);
    bus.i_valid[l]              = 1'b1;
    bus.i_unit[l*S +: S]        = S'(unit);
    bus.i_rs1_tag[l*7 +: 7]     = t1;
    bus.i_rs1_data[l*32 +: 32]  = d1;
    bus.i_rs2_tag[l*7 +: 7]     = t2;
    bus.i_rs2_data[l*32 +: 32]  = d2;
    bus.i_payload[l*PL +: PL]   = pl;
  endtask

  task automatic set_wb(input int p, input logic v, input logic [6:0] tag, input logic [31:0] data);
    bus.i_wb_valid[p]        = v;
    bus.i_wb_tag[p*7 +: 7]   = tag;
    bus.i_wb_data[p*32 +: 32] = data;
  endtask

  task automatic push(input int u, input logic [31:0] r1, input logic [31:0] r2, input logic [47:0] pl);
    exp_t e;
    e.rs1 = r1;
    e.rs2 = r2;
    e.pl  = pl;
    sbq[u].push_back(e);
  endtask

  // Monitor: a slot leaving the crossbar must match the oldest expectation for that unit.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        for (int u = 0; u < U; u++) begin
          if (bus.o_fu_valid[u] && bus.i_fu_ready[u]) begin
            if (sbq[u].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_unexpected_u%0d actual=valid required=empty", u);
            end else begin
              e = sbq[u].pop_front();
              check($sformatf("sb_rs1_u%0d", u), 64'(bus.o_fu_rs1[u*32 +: 32]), 64'(e.rs1));
              check($sformatf("sb_rs2_u%0d", u), 64'(bus.o_fu_rs2[u*32 +: 32]), 64'(e.rs2));
              check($sformatf("sb_pl_u%0d", u), 64'(bus.o_fu_payload[u*PL +: PL]), 64'(e.pl));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    clear_lanes();
    bus.i_fu_ready  = '1;
    bus3.i_valid    = '0;
    bus3.i_unit     = '0;
    bus3.i_rs1_tag  = '0;
    bus3.i_rs2_tag  = '0;
    bus3.i_rs1_data = '0;
    bus3.i_rs2_data = '0;
    bus3.i_payload  = '0;
    bus3.i_wb_valid = '0;
    bus3.i_wb_tag   = '0;
    bus3.i_wb_data  = '0;
    bus3.i_fu_ready = '1;

    // Reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_fu_valid", 64'(bus.o_fu_valid), 64'h0);
    check("rst_cnt", 64'(bus.o_conflict_cnt), 64'h0);
    check("rst_err", 64'(bus.o_err), 64'h0);
    check("rst_ready", 64'(bus.o_ready), 64'h0);
    for (int u = 0; u < U; u++) begin
      check($sformatf("rst_rs1_u%0d", u), 64'(bus.o_fu_rs1[u*32 +: 32]), 64'h0);
      check($sformatf("rst_pl_u%0d", u), 64'(bus.o_fu_payload[u*PL +: PL]), 64'h0);
    end
    bus.i_fu_ready = '0;
    #1;
    check("idle_ready_fu0", 64'(bus.o_ready), 64'h0);
    @(negedge clk);
    bus.i_fu_ready = '1;
    #1;
    check("idle_fu_valid", 64'(bus.o_fu_valid), 64'h0);

    // Two lanes to distinct units, WB port2 bypasses tag 5
    @(negedge clk);
    clear_lanes();
    set_lane(0, 1, 7'd5, 32'h11, 7'd6, 32'h22, 48'h1111);
    set_lane(1, 2, 7'd0, 32'h33, 7'd5, 32'h44, 48'h2222);
    set_wb(2, 1'b1, 7'd5, 32'hAA);
    #1;
    check("a_ready", 64'(bus.o_ready), 64'h3);
    push(1, 32'hAA, 32'h22, 48'h1111);
    push(2, 32'h33, 32'hAA, 48'h2222);
    @(negedge clk);
    clear_lanes();
    #1;
    check("a_fu_valid", 64'(bus.o_fu_valid), 64'h6);
    check("a_u1_rs1", 64'(bus.o_fu_rs1[32 +: 32]), 64'hAA);
    @(negedge clk);
    #1;
    check("a_drained", 64'(bus.o_fu_valid), 64'h0);

    // Tag 0 never bypassed, lowest matching WB port wins, invalid WB ignored
    @(negedge clk);
    clear_lanes();
    set_lane(2, 0, 7'd0, 32'h55, 7'd9, 32'h66, 48'h3333);
    set_lane(0, 3, 7'd9, 32'h77, 7'd1, 32'h88, 48'h4444);
    set_wb(0, 1'b1, 7'd0, 32'hFF);
    set_wb(1, 1'b1, 7'd9, 32'h1);
    set_wb(2, 1'b0, 7'd1, 32'hDEAD);
    set_wb(3, 1'b1, 7'd9, 32'h3);
    #1;
    check("b_ready", 64'(bus.o_ready), 64'h5);
    push(0, 32'h55, 32'h1, 48'h3333);
    push(3, 32'h1, 32'h88, 48'h4444);

    // Three lanes to unit3: lane0 wins, two lane-cycles lost
    @(negedge clk);
    clear_lanes();
    set_lane(0, 3, 7'd0, 32'h100, 7'd0, 32'h101, 48'h5);
    set_lane(1, 3, 7'd0, 32'h200, 7'd0, 32'h201, 48'h6);
    set_lane(2, 3, 7'd0, 32'h300, 7'd0, 32'h301, 48'h7);
    #1;
    check("c_ready", 64'(bus.o_ready), 64'h1);
    push(3, 32'h100, 32'h101, 48'h5);
    @(negedge clk);
    clear_lanes();
    #1;
    check("c_cnt", 64'(bus.o_conflict_cnt), 64'h2);

    // Lanes 1 and 2 to unit2 with lane0 idle: lane1 wins
    @(negedge clk);
    clear_lanes();
    set_lane(1, 2, 7'd0, 32'h61, 7'd0, 32'h62, 48'h61);
    set_lane(2, 2, 7'd0, 32'h71, 7'd0, 32'h72, 48'h71);
    #1;
    check("p_ready", 64'(bus.o_ready), 64'h2);
    push(2, 32'h61, 32'h62, 48'h61);
    @(negedge clk);
    clear_lanes();
    #1;
    check("p_cnt", 64'(bus.o_conflict_cnt), 64'h3);

    // Back-pressure on unit0, held slot must not re-snoop, same-cycle refill
    @(negedge clk);
    clear_lanes();
    bus.i_fu_ready = 4'b1110;
    set_lane(0, 0, 7'd12, 32'hA0, 7'd0, 32'hA1, 48'h10);
    #1;
    check("d1_ready", 64'(bus.o_ready), 64'h1);
    push(0, 32'hA0, 32'hA1, 48'h10);
    @(negedge clk);
    clear_lanes();
    set_lane(0, 0, 7'd0, 32'hB0, 7'd12, 32'hB1, 48'h20);
    set_wb(0, 1'b1, 7'd12, 32'hEE);
    #1;
    check("d2_ready_stall", 64'(bus.o_ready), 64'h0);
    check("d2_u0_valid", 64'(bus.o_fu_valid[0]), 64'h1);
    @(negedge clk);
    bus.i_fu_ready = 4'b1111;
    #1;
    check("d3_ready_refill", 64'(bus.o_ready), 64'h1);
    check("d3_u0_rs1_held", 64'(bus.o_fu_rs1[0 +: 32]), 64'hA0);
    push(0, 32'hB0, 32'hEE, 48'h20);
    @(negedge clk);
    clear_lanes();
    #1;
    check("d4_u0_valid", 64'(bus.o_fu_valid[0]), 64'h1);
    check("d4_u0_rs2", 64'(bus.o_fu_rs2[0 +: 32]), 64'hEE);
    check("d4_cnt_stall_free", 64'(bus.o_conflict_cnt), 64'h3);

    // Saturation: unit3 stalled, all lanes keep colliding on it
    @(negedge clk);
    clear_lanes();
    bus.i_fu_ready = 4'b0111;
    set_lane(0, 3, 7'd0, 32'hC0, 7'd0, 32'hC1, 48'h30);
    set_lane(1, 3, 7'd0, 32'hC2, 7'd0, 32'hC3, 48'h31);
    set_lane(2, 3, 7'd0, 32'hC4, 7'd0, 32'hC5, 48'h32);
    #1;
    check("e_ready_first", 64'(bus.o_ready), 64'h1);
    push(3, 32'hC0, 32'hC1, 48'h30);
    for (int i = 1; i < 40000; i++) begin
      @(negedge clk);
    end
    #1;
    check("e_ready_stalled", 64'(bus.o_ready), 64'h0);
    @(negedge clk);
    clear_lanes();
    #1;
    check("e_cnt_sat", 64'(bus.o_conflict_cnt), 64'hFFFF);
    @(negedge clk);
    clear_lanes();
    bus.i_fu_ready = 4'b1111;
    set_lane(0, 0, 7'd0, 32'hD0, 7'd0, 32'hD1, 48'h40);
    set_lane(1, 0, 7'd0, 32'hD2, 7'd0, 32'hD3, 48'h41);
    #1;
    check("e_ready_u0", 64'(bus.o_ready), 64'h1);
    push(0, 32'hD0, 32'hD1, 48'h40);
    @(negedge clk);
    clear_lanes();
    #1;
    check("e_cnt_hold", 64'(bus.o_conflict_cnt), 64'hFFFF);
    @(negedge clk);
    #1;
    for (int u = 0; u < U; u++) begin
      check($sformatf("e_sb_empty_u%0d", u), 64'(sbq[u].size()), 64'h0);
    end

    // Async reset with slots full
    @(negedge clk);
    bus.i_fu_ready = '0;
    set_lane(0, 0, 7'd0, 32'hE0, 7'd0, 32'hE1, 48'h50);
    set_lane(1, 1, 7'd0, 32'hE2, 7'd0, 32'hE3, 48'h51);
    #1;
    check("f_ready", 64'(bus.o_ready), 64'h3);
    @(negedge clk);
    clear_lanes();
    #1;
    check("f_full", 64'(bus.o_fu_valid), 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("f_async_valid", 64'(bus.o_fu_valid), 64'h0);
    check("f_async_cnt", 64'(bus.o_conflict_cnt), 64'h0);
    check("f_async_rs1", 64'(bus.o_fu_rs1[0 +: 32]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_fu_ready = '1;

    // Out-of-range unit on a 3-unit crossbar
    @(negedge clk);
    #1;
    check("g_err_pre", 64'(bus3.o_err), 64'h0);
    bus3.i_valid          = 3'b011;
    bus3.i_unit           = {2'd0, 2'd2, 2'd3};
    bus3.i_rs1_data[63:32] = 32'h5;
    bus3.i_rs2_data[63:32] = 32'h6;
    bus3.i_payload[95:48]  = 48'h7;
    #1;
    check("g_ready_oor", 64'(bus3.o_ready), 64'h3);
    @(negedge clk);
    bus3.i_valid = '0;
    #1;
    check("g_err_set", 64'(bus3.o_err), 64'h1);
    check("g_fu_valid", 64'(bus3.o_fu_valid), 64'h4);
    check("g_u2_rs1", 64'(bus3.o_fu_rs1[64 +: 32]), 64'h5);
    check("g_cnt", 64'(bus3.o_conflict_cnt), 64'h0);
    check("g_main_err", 64'(bus.o_err), 64'h0);
    @(negedge clk);
    #1;
    check("g_err_sticky", 64'(bus3.o_err), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("g_err_cleared", 64'(bus3.o_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #3;
    for (int u = 0; u < U; u++) begin
      check($sformatf("end_sb_empty_u%0d", u), 64'(sbq[u].size()), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_bypass_xbar.md
Name: issue_bypass_xbar

Overview:
Parametrised successor of the issue-stage operand bypass/demux. It routes up to LANES issued micro-ops to UNITS functional-unit input slots, with one registered slot per unit. Register-file operands are overridden by writeback-bus results on tag match. Same-unit conflicts are arbitrated, and unit back-pressure is honoured with a valid/ready handshake. It sits between the issue queues/register-file read and the functional units.

Parameters:
LANES, 3, number of issue lanes
UNITS, 4, number of functional-unit slots
WB_PORTS, 4, number of writeback buses snooped for bypass
XLEN, 32, operand width
WIDTH_REG, 7, physical register tag width
WIDTH_PL, 48, per-uop payload width (CTRL/BRMASK/UOPCode/PC/IMM/RD, operands excluded)
WIDTH_SEL, $clog2(UNITS) (min 1), unit-select field width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_valid  in  LANES  lane uop valid
i_unit  in  LANES*WIDTH_SEL  target unit per lane
i_rs1_tag, i_rs2_tag  in  LANES*WIDTH_REG  source tags
i_rs1_data, i_rs2_data  in  LANES*XLEN  register-file read data
i_payload  in  LANES*WIDTH_PL  remaining uop fields
o_ready  out  LANES  lane accepted this cycle
i_wb_valid  in  WB_PORTS  writeback valid
i_wb_tag  in  WB_PORTS*WIDTH_REG  writeback dest tag
i_wb_data  in  WB_PORTS*XLEN  writeback result
o_fu_valid  out  UNITS  slot holds a uop
o_fu_rs1, o_fu_rs2  out  UNITS*XLEN  resolved operands
o_fu_payload  out  UNITS*WIDTH_PL  payload
i_fu_ready  in  UNITS  unit consumes slot this cycle
o_conflict_cnt  out  16  saturating count of lane-cycles lost to arbitration
o_err  out  1  sticky: valid lane targeted unit index >= UNITS

Behaviour:
- Reset (i_rst_n=0, async): o_fu_valid=0, o_fu_rs1/rs2/payload=0, o_conflict_cnt=0, o_err=0. Reset asserted mid-transfer drops all held uops.
- Operand resolve, combinational per lane and per source:
  - If tag != 0 and some i_wb_valid[p] has i_wb_tag[p]==tag, use i_wb_data of the lowest matching p.
  - Otherwise use the register-file data.
  - Tag 0 is never bypassed; its data passes through unchanged.
- Slot free for unit u: !o_fu_valid[u] | i_fu_ready[u] (same-cycle refill allowed).
- Arbitration: among valid lanes targeting unit u, the lowest lane index wins.
  - o_ready[l] = i_valid[l] & won[l] & slot_free[i_unit[l]].
  - o_ready is purely combinational from current inputs and slot state. No lane-to-lane dependency beyond priority.
- Out-of-range i_unit (only when UNITS is not a power of 2): o_ready[l]=1 (uop dropped), o_err set. o_err clears only on reset.
- Slot update at posedge:
  - If a lane is accepted into u: load resolved operands and payload, o_fu_valid[u]=1.
  - Else if i_fu_ready[u]: o_fu_valid[u]=0, data held.
  - Else hold.
- Latency: accepted at cycle t, presented at o_fu_* in cycle t+1.
- Held slots do not re-snoop writeback. Operands are final once captured.
- i_fu_ready while !o_fu_valid is ignored.
- o_conflict_cnt increments by popcount of lanes with i_valid & !won. Slot-full stalls do not count. It saturates at 16'hFFFF.
- A lane not ready must hold its inputs stable. The block does not check this.

Decomposition:
- Shared package: WB-port/lane index helpers, tag-zero constant, the operand-resolve priority function.
- One natural sub-module: bypass_resolve, instantiated 2*LANES times. Inputs are tag, rf data and the WB buses; output is the resolved operand.
- Arbitration and slot registers stay in the top module.

Test Plan:
- Reset then idle: all o_fu_valid=0, o_conflict_cnt=0, o_ready=0 regardless of i_fu_ready.
- Lane0→unit1 (rs1_tag=5, rf=0x11), lane1→unit2, WB port2 tag=5 data=0xAA → both ready; next cycle o_fu_rs1[unit1]=0xAA, unit2 valid.
- Tag 0 with WB tag 0 valid, data 0xFF → operand keeps rf value; two WB ports both matching tag 9 (p1=0x1, p3=0x3) → 0x1.
- Lanes 0, 1 and 2 all target unit3 → only o_ready[0]=1, conflict_cnt +2; repeat 40000 cycles → counter saturates at 0xFFFF.
- Unit0 valid with i_fu_ready=0 and lane0 targets unit0 → o_ready[0]=0, slot held. Then i_fu_ready=1 in the same cycle as lane0 → accepted, back-to-back, new uop visible next cycle.
- UNITS=3, i_unit=3 valid → o_ready=1, o_err=1 sticky until i_rst_n pulse. Assert reset with slots full → o_fu_valid=0 immediately (async).
